// File: rtl/sim_video_out_if.sv
// sim_video_out_if: core-side video/audio inputs and conditioned outputs of sim_video_out
//   rgb_in {B,G,R}, hs/vs/hb/vb_in, audio_in      core -> conditioner
//   ce_pix, VGA_R/G/B/HS/VS/HB/VB, AUDIO_L/R      conditioner -> sim top / wrapper
//   line_count, frame_count                       present only with SIM_VIDEO_STATS_EN
interface sim_video_out_if #(
  parameter int IN_BITS  = 3,
  parameter int AUD_BITS = 8
);
  logic [3*IN_BITS-1:0] rgb_in;
  logic                 hs_in, vs_in, hb_in, vb_in;
  logic [AUD_BITS-1:0]  audio_in;
  logic                 ce_pix;
  logic [7:0]           VGA_R, VGA_G, VGA_B;
  logic                 VGA_HS, VGA_VS, VGA_HB, VGA_VB;
  logic [15:0]          AUDIO_L, AUDIO_R;
`ifdef SIM_VIDEO_STATS_EN
  logic [9:0]           line_count;
  logic [15:0]          frame_count;
  modport master (
    input  rgb_in, hs_in, vs_in, hb_in, vb_in, audio_in,
    output ce_pix, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_HB, VGA_VB, AUDIO_L, AUDIO_R,
    output line_count, frame_count
  );
  modport slave (
    output rgb_in, hs_in, vs_in, hb_in, vb_in, audio_in,
    input  ce_pix, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_HB, VGA_VB, AUDIO_L, AUDIO_R,
    input  line_count, frame_count
  );
`else
  modport master (
    input  rgb_in, hs_in, vs_in, hb_in, vb_in, audio_in,
    output ce_pix, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_HB, VGA_VB, AUDIO_L, AUDIO_R
  );
  modport slave (
    output rgb_in, hs_in, vs_in, hb_in, vb_in, audio_in,
    input  ce_pix, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_HB, VGA_VB, AUDIO_L, AUDIO_R
  );
`endif
endinterface

// File: rtl/sim_video_out.sv
// sim_video_out: pixel-enable generation, colour expansion/blank gating and audio widening
//   clk_48, reset   48 MHz system clock, synchronous active-high reset
//   vid (master)    core inputs in, registered VGA_*/AUDIO_* and ce_pix out
//   SIM_VIDEO_STATS_EN adds line_count/frame_count for the sim frame grabber
module sim_video_out #(
  parameter int CE_DIV   = 4,
  parameter int IN_BITS  = 3,
  parameter int AUD_BITS = 8
) (
  input logic            clk_48,
  input logic            reset,
  sim_video_out_if.master vid
);
  localparam int CW = CE_DIV > 1 ? $clog2(CE_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CE_DIV - 1);
  // MSB-first bit replication so full scale reaches all ones
  function automatic logic [7:0] rep8(input logic [IN_BITS-1:0] v);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[7-i] = v[IN_BITS-1-(i%IN_BITS)];
    return o;
  endfunction
  function automatic logic [15:0] rep16(input logic [AUD_BITS-1:0] v);
    logic [15:0] o;
    for (int i = 0; i < 16; i++) o[15-i] = v[AUD_BITS-1-(i%AUD_BITS)];
    return o;
  endfunction
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_q;
  logic [7:0]    r_q, g_q, b_q, r_d, g_d, b_d;
  logic          hs_q, vs_q, hb_q, vb_q;
  logic [15:0]   aud_q;
  always_comb begin
    cnt_d = cnt_q == CNT_MAX ? '0 : cnt_q + 1'b1;
    r_d   = vid.hb_in | vid.vb_in ? 8'h00 : rep8(vid.rgb_in[IN_BITS-1:0]);
    g_d   = vid.hb_in | vid.vb_in ? 8'h00 : rep8(vid.rgb_in[2*IN_BITS-1:IN_BITS]);
    b_d   = vid.hb_in | vid.vb_in ? 8'h00 : rep8(vid.rgb_in[3*IN_BITS-1:2*IN_BITS]);
  end
  always_ff @(posedge clk_48) begin
    if (reset) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
      {r_q, g_q, b_q} <= '0;
      {hs_q, vs_q, hb_q, vb_q} <= '0;
      aud_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= cnt_q == CNT_MAX;
      aud_q <= rep16(vid.audio_in);
      if (ce_q) begin
        {r_q, g_q, b_q} <= {r_d, g_d, b_d};
        {hs_q, vs_q, hb_q, vb_q} <= {vid.hs_in, vid.vs_in, vid.hb_in, vid.vb_in};
      end
    end
  end
  assign vid.ce_pix  = ce_q;
  assign vid.VGA_R   = r_q;
  assign vid.VGA_G   = g_q;
  assign vid.VGA_B   = b_q;
  assign vid.VGA_HS  = hs_q;
  assign vid.VGA_VS  = vs_q;
  assign vid.VGA_HB  = hb_q;
  assign vid.VGA_VB  = vb_q;
  assign vid.AUDIO_L = aud_q;
  assign vid.AUDIO_R = aud_q;
`ifdef SIM_VIDEO_STATS_EN
  // The registered syncs double as the previous-sample edge history
  logic [9:0]  lc_q, lc_d;
  logic [15:0] fc_q, fc_d;
  logic        hs_rise, vs_rise;
  always_comb begin
    hs_rise = vid.hs_in & ~hs_q;
    vs_rise = vid.vs_in & ~vs_q;
    lc_d    = vs_rise ? 10'd0 : hs_rise && lc_q != 10'h3FF ? lc_q + 10'd1 : lc_q;
    fc_d    = fc_q + {15'd0, vs_rise};
  end
  always_ff @(posedge clk_48) begin
    if (reset) begin
      lc_q <= '0;
      fc_q <= '0;
    end else if (ce_q) begin
      lc_q <= lc_d;
      fc_q <= fc_d;
    end
  end
  assign vid.line_count  = lc_q;
  assign vid.frame_count = fc_q;
`endif
endmodule

// File: tb/tb_sim_video_out.sv
// tb_sim_video_out: scoreboard bench for sim_video_out (CE_DIV=4 and CE_DIV=1 instances)
module tb_sim_video_out;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sim_video_out_if #(.IN_BITS(3), .AUD_BITS(8)) v0 ();
  sim_video_out_if #(.IN_BITS(3), .AUD_BITS(8)) v1 ();
  sim_video_out #(.CE_DIV(4), .IN_BITS(3), .AUD_BITS(8)) u0 (.clk_48(clk), .reset(rst), .vid(v0.master));
  sim_video_out #(.CE_DIV(1), .IN_BITS(3), .AUD_BITS(8)) u1 (.clk_48(clk), .reset(rst), .vid(v1.master));
  typedef struct {
    logic [27:0] vid;
    logic [9:0]  lc;
    logic [15:0] fc;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Monitor: a sample taken in a ce_pix cycle shows up on VGA_* just after the next edge
  always @(posedge clk) begin
    logic ce_prev;
    exp_t e;
    ce_prev = v0.ce_pix;
    #1;
    if (ce_prev && q.size() > 0) begin
      e = q.pop_front();
      chk("video", {v0.VGA_R, v0.VGA_G, v0.VGA_B, v0.VGA_HS, v0.VGA_VS, v0.VGA_HB, v0.VGA_VB}, e.vid);
`ifdef SIM_VIDEO_STATS_EN
      chk("line_count", v0.line_count, e.lc);
      chk("frame_count", v0.frame_count, e.fc);
`endif
    end
  end
  task automatic send(input logic [8:0] rgb, input logic hs, vs, hb, vb,
                      input logic [23:0] erg, input logic [9:0] lc, input logic [15:0] fc);
    exp_t e;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!v0.ce_pix && n < 8);
    if (!v0.ce_pix) chk("ce_timeout", 0, 1);
    v0.rgb_in = rgb;
    {v0.hs_in, v0.vs_in, v0.hb_in, v0.vb_in} = {hs, vs, hb, vb};
    e.vid = {erg, hs, vs, hb, vb};
    e.lc = lc;
    e.fc = fc;
    q.push_back(e);
    @(posedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v0.rgb_in = '0; {v0.hs_in, v0.vs_in, v0.hb_in, v0.vb_in} = '0; v0.audio_in = '0;
    v1.rgb_in = '0; {v1.hs_in, v1.vs_in, v1.hb_in, v1.vb_in} = '0; v1.audio_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", v0.ce_pix, 0);
    chk("rst_rgb", {v0.VGA_R, v0.VGA_G, v0.VGA_B}, 0);
    chk("rst_audio", v0.AUDIO_L, 0);
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1 chk($sformatf("ce_cycle%0d", k), v0.ce_pix, (k % 4) == 0);
    end
    send(9'b000_111_101, 0, 0, 0, 0, 24'hB6_FF_00, 0, 0);
    @(negedge clk);
    v0.rgb_in = '0;
    v0.hb_in = 1'b1;
    @(posedge clk);
    #1 chk("hold_r", v0.VGA_R, 8'hB6);
    chk("hold_hb", v0.VGA_HB, 0);
    send(9'b110_001_010, 0, 0, 0, 0, 24'h49_24_DB, 0, 0);
    send(9'b000_111_101, 0, 0, 1, 0, 24'h00_00_00, 0, 0);
    send(9'b111_111_111, 0, 0, 0, 1, 24'h00_00_00, 0, 0);
    send(9'b111_111_111, 0, 0, 0, 0, 24'hFF_FF_FF, 0, 0);
    send(9'b000_000_000, 0, 0, 0, 0, 24'h00_00_00, 0, 0);
    send(9'b0, 1, 0, 0, 0, 24'h0, 1, 0);
    send(9'b0, 0, 0, 0, 0, 24'h0, 1, 0);
    send(9'b0, 1, 0, 0, 0, 24'h0, 2, 0);
    send(9'b0, 0, 0, 0, 0, 24'h0, 2, 0);
    send(9'b0, 1, 0, 0, 0, 24'h0, 3, 0);
    send(9'b0, 0, 0, 0, 0, 24'h0, 3, 0);
    send(9'b0, 1, 1, 0, 0, 24'h0, 0, 1);
    send(9'b0, 0, 0, 0, 0, 24'h0, 0, 1);
    @(negedge clk) v0.audio_in = 8'hA5;
    @(posedge clk);
    #1 chk("audio_l", v0.AUDIO_L, 16'hA5A5);
    chk("audio_r", v0.AUDIO_R, 16'hA5A5);
    @(negedge clk) v0.audio_in = 8'h3C;
    @(posedge clk);
    #1 chk("audio_l2", v0.AUDIO_L, 16'h3C3C);
    @(negedge clk) v1.rgb_in = 9'b000_111_101;
    @(posedge clk);
    #1 chk("ce1_r", v1.VGA_R, 8'hB6);
    chk("ce1_ce", v1.ce_pix, 1);
    @(negedge clk) v1.rgb_in = 9'b110_001_010;
    @(posedge clk);
    #1 chk("ce1_rgb", {v1.VGA_R, v1.VGA_G, v1.VGA_B}, 24'h49_24_DB);
    chk("ce1_ce2", v1.ce_pix, 1);
    send(9'b000_000_111, 0, 0, 0, 0, 24'hFF_00_00, 0, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("midrst_rgb", {v0.VGA_R, v0.VGA_G, v0.VGA_B}, 0);
    chk("midrst_ce", v0.ce_pix, 0);
    chk("midrst_audio", v0.AUDIO_L, 0);
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1 chk($sformatf("rel_ce%0d", k), v0.ce_pix, k == 4);
    end
    repeat (2) @(posedge clk);
    #2 chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
